queue_ctrl: RTL

QUEUE_CTRL -- requirements
Module: queue_ctrl

---
 rtl/queue_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/queue_ctrl.sv
// queue_ctrl: synchronous FIFO queue controller with registered read data,
// registered occupancy flags and drive for a downstream up/down tally counter.
// Optional feature macro: QUEUE_CTRL_ERR_EN adds sticky err_ovf / err_udf.
// Ports:
//   clk, rst (sync, active-high), flush (sync clear)
//   wr_en/wr_data     push request and data
//   rd_en             pop request
//   rd_data/rd_valid  popped entry, valid the cycle after the accepting edge
//   full/empty/count  registered occupancy
//   cnt_load/cnt_en/cnt_d/cnt_value  tally counter load/enable/dir/value
//   err_ovf/err_udf   sticky push-on-full / pop-on-empty (macro only)
module queue_ctrl #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          cnt_load,
    output logic          cnt_en,
    output logic          cnt_d,
    output logic [AW:0]   cnt_value
`ifdef QUEUE_CTRL_ERR_EN
    ,
    output logic          err_ovf,
    output logic          err_udf
`endif
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] mem_q [2**AW];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full_q, empty_q;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          wr_acc, rd_acc;

    // rst and flush both block acceptance so the tally counter never
    // sees an enable while it is being loaded.
    assign wr_acc = wr_en & ~full_q & ~flush & ~rst;
    assign rd_acc = rd_en & ~empty_q & ~flush & ~rst;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
        if (wr_acc && !rd_acc) count_d = count_q + (AW+1)'(1);
        if (rd_acc && !wr_acc) count_d = count_q - (AW+1)'(1);
        if (rst || flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            // Flags track next-state count so they align with count.
            full_q     <= (count_d == DEPTH);
            empty_q    <= (count_d == '0);
            rd_valid_q <= rd_acc;
            if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign cnt_load  = rst | flush;
    assign cnt_en    = wr_acc ^ rd_acc;
    assign cnt_d     = rd_acc & ~wr_acc;
    assign cnt_value = '0;

`ifdef QUEUE_CTRL_ERR_EN
    logic err_ovf_q, err_udf_q;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            if (wr_en && full_q)  err_ovf_q <= 1'b1;
            if (rd_en && empty_q) err_udf_q <= 1'b1;
        end
    end

    assign err_ovf = err_ovf_q;
    assign err_udf = err_udf_q;
`endif

endmodule
